// File: rtl/mips_pkg.sv
// Shared constants for the MIPS front end: instruction width, NOP encoding
// and the default reset fetch address.
package mips_pkg;

  localparam int unsigned     INSTR_W          = 32;
  localparam logic [31:0]     NOP              = 32'h0000_0000;
  localparam logic [31:0]     DEFAULT_RESET_PC = 32'h0000_0000;

  // Clear the byte-offset bits so every fetch address is word aligned.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds the fetched instruction, its PC and PC+4.
// Flush inserts a bubble (NOP, valid low) and takes priority over the enable.
module if_id_reg
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               flush,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic [31:0]        load_pc,
  input  logic               load_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  output logic               valid
);

  always_ff @(posedge clk) begin
    if (rst) begin
      instr    <= NOP;
      pc       <= '0;
      pc_plus4 <= 32'd4;
      valid    <= 1'b0;
    end else if (flush) begin
      // A flushed slot keeps its PC fields; only the instruction is squashed.
      instr    <= NOP;
      valid    <= 1'b0;
    end else if (en) begin
      instr    <= load_instr;
      pc       <= load_pc;
      pc_plus4 <= load_pc + 32'd4;
      valid    <= load_valid;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC sequencing, ROM address generation with
// stall/redirect handling, IF/ID register and delivered-instruction counter.
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter bit          WORD_ADDR = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_target,
  output logic [31:0]        imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] id_instr,
  output logic [31:0]        id_pc,
  output logic [31:0]        id_pc_plus4,
  output logic               id_valid,
  output logic [31:0]        fetch_cnt
);

  logic [31:0] pc_q;
  logic [31:0] req_pc;
  logic        req_valid;
  logic [31:0] target;
  logic [31:0] fetch_pc;
  logic        advance;

  assign target  = align_word(redirect_target);
  assign advance = !stall && !redirect_valid;

  // The address issued this cycle always becomes req_pc at the edge, so
  // imem_rdata in the next cycle always belongs to req_pc.
  always_comb begin
    fetch_pc = pc_q;
    if (rst)                 fetch_pc = RESET_PC;
    else if (redirect_valid) fetch_pc = target;
    else if (stall)          fetch_pc = req_pc;
    imem_addr = WORD_ADDR ? (fetch_pc >> 2) : fetch_pc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      req_pc    <= RESET_PC;
      req_valid <= 1'b0;
      fetch_cnt <= '0;
    end else if (redirect_valid) begin
      pc_q      <= target + 32'd4;
      req_pc    <= target;
      req_valid <= 1'b1;
    end else if (!stall) begin
      pc_q      <= pc_q + 32'd4;
      req_pc    <= pc_q;
      req_valid <= 1'b1;
      if (req_valid) fetch_cnt <= fetch_cnt + 32'd1;
    end
  end

  if_id_reg u_if_id (
    .clk        (clk),
    .rst        (rst),
    .en         (advance),
    .flush      (redirect_valid),
    .load_instr (imem_rdata),
    .load_pc    (req_pc),
    .load_valid (req_valid),
    .instr      (id_instr),
    .pc         (id_pc),
    .pc_plus4   (id_pc_plus4),
    .valid      (id_valid)
  );

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first instruction byte address after reset.
REQ-002 Parameter WORD_ADDR, default 1; 1 = imem_addr is a word index (PC>>2), 0 = byte address.
REQ-003 clk  input  1  rising-edge clock; the only clock.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  hazard hold; freezes PC and the IF/ID register.
REQ-006 redirect_valid  input  1  branch/jump taken this cycle.
REQ-007 redirect_target  input  32  new PC byte address.
REQ-008 imem_addr  output  32  address to the instruction memory_rom A port; combinational.
REQ-009 imem_rdata  input  32  memory_rom RD, valid one cycle after the address is sampled.
REQ-010 id_instr  output  32  instruction to decode.
REQ-011 id_pc  output  32  byte address of id_instr.
REQ-012 id_pc_plus4  output  32  id_pc + 4, modulo 2^32.
REQ-013 id_valid  output  1  id_* holds a real instruction.
REQ-014 fetch_cnt  output  32  count of instructions delivered to decode.

Function
REQ-015 Internal state SHALL be: pc_q (next address to issue), req_pc and req_valid (address in flight to ROM), and the IF/ID register.
REQ-016 Fetch address SHALL be redirect_target when redirect_valid=1, else req_pc when stall=1, else pc_q; imem_addr SHALL be that value, or that value >>2 when WORD_ADDR=1.
REQ-017 Normal cycle (no stall, no redirect): id_instr<=imem_rdata, id_pc<=req_pc, id_valid<=req_valid, req_pc<=pc_q, req_valid<=1, pc_q<=pc_q+4.
REQ-018 Stall cycle (stall=1, redirect_valid=0): pc_q, req_pc, req_valid and all id_* SHALL hold; re-issuing req_pc keeps imem_rdata coherent.
REQ-019 Redirect cycle: redirect_valid SHALL take priority over stall.
REQ-020 On a redirect: req_pc<=target, req_valid<=1, pc_q<=target+4, id_valid<=0, and id_instr<=NOP.
REQ-021 A redirect SHALL cost exactly one bubble: the target instruction reaches decode on the second edge after redirect_valid is sampled.
REQ-022 Bits [1:0] of redirect_target SHALL be ignored (forced to 0).
REQ-023 PC arithmetic SHALL wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-024 fetch_cnt SHALL increment by 1 on every edge that loads id_valid<=1 from a normal cycle.
REQ-025 fetch_cnt SHALL wrap at 2^32 and SHALL hold during stall.
REQ-026 Outputs SHALL be registered except imem_addr.

Reset
REQ-027 While rst=1 at an edge: pc_q<=RESET_PC, req_pc<=RESET_PC, req_valid<=0, id_valid<=0, id_instr<=NOP, id_pc<=0, id_pc_plus4<=4, fetch_cnt<=0.
REQ-028 rst SHALL override stall and redirect_valid.
REQ-029 During reset, imem_addr SHALL present RESET_PC (scaled per WORD_ADDR).
REQ-030 First valid instruction (RESET_PC): id_valid=1 after the second rising edge following rst deassertion.
REQ-031 Reset asserted mid-stall or mid-redirect SHALL discard all in-flight state.

Structure
REQ-032 Shared package mips_pkg SHALL hold NOP (32'h0000_0000), the default RESET_PC and the instruction width constant.
REQ-033 The IF/ID register SHALL be a sub-module if_id_reg (enable = !stall, flush = redirect_valid, sync reset).
REQ-034 PC logic and fetch_cnt SHALL stay in instr_fetch.

Verification (bench pairs instr_fetch with memory_rom; ROM word k = 32'h1000_0000+k)
REQ-035 Reset release, no stall: id_instr sequence 1000_0000, 1000_0001, 1000_0002 on consecutive cycles; id_pc 0, 4, 8; fetch_cnt 1, 2, 3.
REQ-036 stall high 3 cycles while id_pc=4: id_* hold id_pc=4, fetch_cnt holds; after release next id_pc=8, no skipped or duplicated instruction.
REQ-037 redirect_valid with target 32'h40 while id_pc=8: next cycle id_valid=0; following cycle id_pc=0x40, id_instr=1000_0010.
REQ-038 redirect_valid and stall high together, target 32'h23: redirect wins; id_pc=0x20 two edges later.
REQ-039 redirect to 32'hFFFF_FFFC with WORD_ADDR=0: id_pc sequence FFFF_FFFC then 0000_0000; id_pc_plus4 = 0 for the first.
REQ-040 rst pulsed for 1 cycle during a stall: id_valid=0, fetch_cnt=0; fetch restarts at RESET_PC with REQ-030 timing.
